maxpool_read_sequencer: RTL

MAXPOOL_READ_SEQUENCER -- requirements
Module: maxpool_read_sequencer

---
 rtl/maxpool_pkg.sv | 15 +
 rtl/maxpool_addr_gen.sv | 44 ++++
 rtl/maxpool_read_sequencer.sv | 88 ++++++++
 3 files changed

// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared FSM state type and default map geometry for the 2x2 max-pool read sequencer.
//   state_t      : IDLE / READ / DRAIN sequencer states
//   MAP_WIDTH    : default convolution-result map columns
//   MAP_HEIGHT   : default convolution-result map rows
//   DATA_WIDTH   : default signed pixel width
//   COUNTER_WIDTH: default read-address width
//   OUT_WIDTH    : default pooled-address width
package maxpool_pkg;
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   localparam int MAP_WIDTH     = 26;
   localparam int MAP_HEIGHT    = 26;
   localparam int DATA_WIDTH    = 16;
   localparam int COUNTER_WIDTH = 10;
   localparam int OUT_WIDTH     = 8;
endpackage

// File: rtl/maxpool_addr_gen.sv
// maxpool_addr_gen: walks 2x2 windows in raster order and produces the read address of each sample.
//   clk, rst  : clock, asynchronous active-low reset
//   en        : advance to the next sample (one read issued this cycle)
//   rd_addr   : address of the current sample (TL, TR, BL, BR within the window)
//   first     : current sample is the top-left of its window
//   last_sub  : current sample is the bottom-right of its window
//   last      : current sample is the final read of the map
module maxpool_addr_gen import maxpool_pkg::*; #(
   parameter int mapWidth     = MAP_WIDTH,
   parameter int mapHeight    = MAP_HEIGHT,
   parameter int counterWidth = COUNTER_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   output logic [counterWidth-1:0] rd_addr,
   output logic                    first,
   output logic                    last_sub,
   output logic                    last
);
   logic [counterWidth-1:0] r, c;
   logic [1:0]              s;
   logic                    c_end, r_end;
   assign c_end    = c == counterWidth'(mapWidth / 2 - 1);
   assign r_end    = r == counterWidth'(mapHeight / 2 - 1);
   assign first    = s == 2'd0;
   assign last_sub = s == 2'd3;
   assign last     = last_sub && c_end && r_end;
   // s[1] selects the lower row of the window, s[0] the right column
   assign rd_addr  = ((r << 1) + counterWidth'(s[1])) * counterWidth'(mapWidth) + (c << 1) + counterWidth'(s[0]);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r <= '0;
         c <= '0;
         s <= '0;
      end else if (en) begin
         s <= s + 1'b1;
         if (last_sub) begin
            c <= c_end ? '0 : c + 1'b1;
            if (c_end) r <= r_end ? '0 : r + 1'b1;
         end
      end
   end
endmodule

// File: rtl/maxpool_read_sequencer.sv
// maxpool_read_sequencer: streams a conv-result map through 2x2 max pooling and writes one result per window.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : one-cycle request to pool a full map (ignored while busy)
//   busy, done          : map in progress / one-cycle completion pulse with the last result
//   rd_en, rd_addr      : read port into the conv-result memory
//   rd_data             : signed sample, valid one cycle after rd_en
//   out_valid, out_addr, out_data : pooled-memory write port
// Build option: define MAXPOOL_RELU_EN to clamp negative window maxima to zero.
module maxpool_read_sequencer import maxpool_pkg::*; #(
   parameter int mapWidth     = MAP_WIDTH,
   parameter int mapHeight    = MAP_HEIGHT,
   parameter int dataWidth    = DATA_WIDTH,
   parameter int counterWidth = COUNTER_WIDTH,
   parameter int outWidth     = OUT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        rd_en,
   output logic [counterWidth-1:0]     rd_addr,
   input  logic signed [dataWidth-1:0] rd_data,
   output logic                        out_valid,
   output logic [outWidth-1:0]         out_addr,
   output logic signed [dataWidth-1:0] out_data
);
   localparam int NW = mapWidth * mapHeight / 4;
   if ((mapWidth % 2) != 0 || (mapHeight % 2) != 0) begin : g_odd_map
      $error("maxpool_read_sequencer: mapWidth and mapHeight must be even");
   end
   state_t                      state, state_nx;
   logic                        a_first, a_last_sub, a_last;
   logic                        v1, f1, l1;
   logic signed [dataWidth-1:0] acc, mx, res;
   logic [outWidth-1:0]         wcnt;
   maxpool_addr_gen #(
      .mapWidth(mapWidth), .mapHeight(mapHeight), .counterWidth(counterWidth)
   ) u_addr (
      .clk(clk), .rst(rst), .en(rd_en), .rd_addr(rd_addr),
      .first(a_first), .last_sub(a_last_sub), .last(a_last)
   );
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = READ;
         READ:    if (a_last) state_nx = DRAIN;
         DRAIN:   if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      rd_en = state == READ;
      busy  = state != IDLE;
   end
   // first sample of a window reloads rather than compares, so nothing leaks between windows
   assign mx = (!f1 && acc > rd_data) ? acc : rd_data;
`ifdef MAXPOOL_RELU_EN
   assign res = mx[dataWidth-1] ? '0 : mx;
`else
   assign res = mx;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         v1        <= 1'b0;
         f1        <= 1'b0;
         l1        <= 1'b0;
         acc       <= '0;
         wcnt      <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         v1        <= rd_en;
         f1        <= rd_en & a_first;
         l1        <= rd_en & a_last_sub;
         if (v1) acc <= mx;
         out_valid <= l1;
         done      <= l1 && wcnt == outWidth'(NW - 1);
         if (l1) begin
            out_data <= res;
            out_addr <= wcnt;
            wcnt     <= (wcnt == outWidth'(NW - 1)) ? '0 : wcnt + 1'b1;
         end
      end
   end
endmodule
